// File: rtl/wb_pkg.sv
// Shared writeback types: the register-file write request and architectural register constants.
package wb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NUM_REGS     = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [4:0]              addr;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered FPU results. The head is visible combinationally, and a pop takes effect at the clock edge.
// A push while full or a pop while empty is ignored. Pointers wrap modulo DEPTH, so DEPTH must be a power of two.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter. The priority order is: integer, then the FIFO head, then FPU bypass. The rd_* outputs are registered with one cycle of latency.
// The FPU is backpressured only by a full FIFO and the integer pipe is never stalled. The WB_STATS_EN macro adds the stall_cnt_o counter.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = XLEN_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                int_valid_i,
  input  logic [4:0]          int_rd_addr_i,
  input  logic [XLEN-1:0]     int_rd_data_i,
  input  logic                fpu_valid_i,
  output logic                fpu_ready_o,
  input  logic [4:0]          fpu_rd_addr_i,
  input  logic [XLEN-1:0]     fpu_rd_data_i,
  input  logic                issue_valid_i,
  input  logic [4:0]          issue_rd_addr_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [4:0]          rd_addr_o,
  output logic [XLEN-1:0]     rd_data_o,
`ifdef WB_STATS_EN
  output logic                rd_wren_o,
  output logic [15:0]         stall_cnt_o
`else
  output logic                rd_wren_o
`endif
);

  wb_req_t int_req;
  wb_req_t fpu_req;
  wb_req_t head_req;
  wb_req_t sel_req;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fpu_hs;
  logic    sel_vld;
  logic    sel_fpu;
  logic    fifo_push;
  logic    fifo_pop;
  logic    bypass;
  logic    out_fpu;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;

  // XLEN must match the package request width.
  assign int_req = {int_rd_addr_i, int_rd_data_i};
  assign fpu_req = {fpu_rd_addr_i, fpu_rd_data_i};

  assign fpu_ready_o = !fifo_full;
  assign fpu_hs      = fpu_valid_i && fpu_ready_o;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(wb_req_t))
  ) u_fpu_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fpu_req),
    .head  (head_req),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    sel_vld  = 1'b0;
    sel_fpu  = 1'b0;
    sel_req  = int_req;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    if (int_valid_i) begin
      sel_vld = 1'b1;
    end else if (!fifo_empty) begin
      sel_vld  = 1'b1;
      sel_fpu  = 1'b1;
      sel_req  = head_req;
      fifo_pop = 1'b1;
    end else if (fpu_hs) begin
      sel_vld = 1'b1;
      sel_fpu = 1'b1;
      sel_req = fpu_req;
      bypass  = 1'b1;
    end
    fifo_push = fpu_hs && !bypass;
  end

  // An x0 result still consumes its slot but never raises the write enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_wren_o <= 1'b0;
      rd_addr_o <= REG_X0;
      rd_data_o <= '0;
      out_fpu   <= 1'b0;
    end else begin
      rd_wren_o <= sel_vld && (sel_req.addr != REG_X0);
      out_fpu   <= sel_fpu;
      if (sel_vld) begin
        rd_addr_o <= sel_req.addr;
        rd_data_o <= sel_req.data;
      end
    end
  end

  always_comb begin
    busy_nxt = busy_q;
    if (rd_wren_o && out_fpu) busy_nxt[rd_addr_o] = 1'b0;
    if (issue_valid_i && (issue_rd_addr_i != REG_X0)) busy_nxt[issue_rd_addr_i] = 1'b1;
    busy_nxt[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_nxt;
  end

  assign busy_o = busy_q;

`ifdef WB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (fpu_valid_i && !fpu_ready_o && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter. It covers the reset state, bypass, priority, FIFO backpressure, the scoreboard, x0 handling and reset while busy.
module tb_wb_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        int_valid_i;
  logic [4:0]  int_rd_addr_i;
  logic [31:0] int_rd_data_i;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic [4:0]  fpu_rd_addr_i;
  logic [31:0] fpu_rd_data_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_addr_i;
  logic [31:0] busy_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wren_o;
`ifdef WB_STATS_EN
  logic [15:0] stall_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.FIFO_DEPTH(2), .XLEN(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .int_valid_i     (int_valid_i),
    .int_rd_addr_i   (int_rd_addr_i),
    .int_rd_data_i   (int_rd_data_i),
    .fpu_valid_i     (fpu_valid_i),
    .fpu_ready_o     (fpu_ready_o),
    .fpu_rd_addr_i   (fpu_rd_addr_i),
    .fpu_rd_data_i   (fpu_rd_data_i),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_addr_i (issue_rd_addr_i),
    .busy_o          (busy_o),
    .rd_addr_o       (rd_addr_o),
    .rd_data_o       (rd_data_o),
`ifdef WB_STATS_EN
    .rd_wren_o       (rd_wren_o),
    .stall_cnt_o     (stall_cnt_o)
`else
    .rd_wren_o       (rd_wren_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    int_valid_i     = 1'b0;
    int_rd_addr_i   = '0;
    int_rd_data_i   = '0;
    fpu_valid_i     = 1'b0;
    fpu_rd_addr_i   = '0;
    fpu_rd_data_i   = '0;
    issue_valid_i   = 1'b0;
    issue_rd_addr_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int exp_rdy [7] = '{1, 1, 0, 0, 0, 1, 1};
  int fidx;

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    step();
    step();
    check("rst_wren", rd_wren_o, 0);
    check("rst_addr", rd_addr_o, 0);
    check("rst_data", rd_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rdy", fpu_ready_o, 1);
    rst_i = 1'b0;

    // 1: FPU bypass with an empty FIFO
    fpu_valid_i = 1'b1; fpu_rd_addr_i = 5'd5; fpu_rd_data_i = 32'h3F800000;
    check("t1_rdy", fpu_ready_o, 1);
    step();
    idle_inputs();
    check("t1_wren", rd_wren_o, 1);
    check("t1_addr", rd_addr_o, 5);
    check("t1_data", rd_data_o, 32'h3F800000);
    step();
    check("t1_idle_wren", rd_wren_o, 0);
    check("t1_rdy_after", fpu_ready_o, 1);

    // 2: integer wins, FPU result follows from the FIFO
    int_valid_i = 1'b1; int_rd_addr_i = 5'd3; int_rd_data_i = 32'd7;
    fpu_valid_i = 1'b1; fpu_rd_addr_i = 5'd4; fpu_rd_data_i = 32'd9;
    step();
    idle_inputs();
    check("t2_int_wren", rd_wren_o, 1);
    check("t2_int_addr", rd_addr_o, 3);
    check("t2_int_data", rd_data_o, 7);
    step();
    check("t2_fpu_wren", rd_wren_o, 1);
    check("t2_fpu_addr", rd_addr_o, 4);
    check("t2_fpu_data", rd_data_o, 9);
    step();
    check("t2_idle_wren", rd_wren_o, 0);
    check("t2_hold_addr", rd_addr_o, 4);

    // 3: integer holds the port for 4 cycles while the FPU offers 3 results
    fidx = 0;
    for (int c = 0; c < 7; c++) begin
      int_valid_i   = (c < 4);
      int_rd_addr_i = 5'(10 + c);
      int_rd_data_i = 32'(100 + c);
      fpu_valid_i   = (fidx < 3);
      fpu_rd_addr_i = 5'(20 + fidx);
      fpu_rd_data_i = 32'(200 + fidx);
      check($sformatf("t3_rdy_c%0d", c), fpu_ready_o, exp_rdy[c]);
      @(posedge clk_i);
      if (fpu_valid_i && fpu_ready_o) fidx++;
      #1;
      check($sformatf("t3_wren_c%0d", c), rd_wren_o, 1);
      check($sformatf("t3_addr_c%0d", c), rd_addr_o, (c < 4) ? 10 + c : 20 + c - 4);
      check($sformatf("t3_data_c%0d", c), rd_data_o, (c < 4) ? 100 + c : 200 + c - 4);
    end
    idle_inputs();
    check("t3_accepts", fidx, 3);
    step();
    check("t3_drain_wren", rd_wren_o, 0);

    // 4: scoreboard set, integer write does not clear, FPU write clears
    issue_valid_i = 1'b1; issue_rd_addr_i = 5'd8;
    step();
    idle_inputs();
    check("t4_set", busy_o, 32'h100);
    int_valid_i = 1'b1; int_rd_addr_i = 5'd8; int_rd_data_i = 32'hAA;
    step();
    idle_inputs();
    check("t4_int_wren", rd_wren_o, 1);
    check("t4_int_no_clr", busy_o, 32'h100);
    step();
    fpu_valid_i = 1'b1; fpu_rd_addr_i = 5'd8; fpu_rd_data_i = 32'h55;
    step();
    idle_inputs();
    check("t4_fpu_addr", rd_addr_o, 8);
    check("t4_busy_inflight", busy_o, 32'h100);
    step();
    check("t4_clr", busy_o, 0);
    issue_valid_i = 1'b1; issue_rd_addr_i = 5'd8;
    step();
    idle_inputs();
    check("t4_reset_set", busy_o, 32'h100);
    fpu_valid_i = 1'b1; fpu_rd_addr_i = 5'd8; fpu_rd_data_i = 32'h66;
    step();
    idle_inputs();
    issue_valid_i = 1'b1; issue_rd_addr_i = 5'd8;
    check("t4_wren_x8", rd_wren_o, 1);
    step();
    idle_inputs();
    check("t4_set_wins", busy_o, 32'h100);
    fpu_valid_i = 1'b1; fpu_rd_addr_i = 5'd8; fpu_rd_data_i = 32'h77;
    step();
    idle_inputs();
    step();
    check("t4_final_clr", busy_o, 0);

    // 5: x0 result and x0 issue
    fpu_valid_i = 1'b1; fpu_rd_addr_i = 5'd0; fpu_rd_data_i = 32'd1;
    issue_valid_i = 1'b1; issue_rd_addr_i = 5'd0;
    step();
    idle_inputs();
    check("t5_x0_wren", rd_wren_o, 0);
    check("t5_x0_busy", busy_o, 0);
    check("t5_rdy", fpu_ready_o, 1);
    step();
    check("t5_after_wren", rd_wren_o, 0);

    // 6: reset with a full FIFO and pending busy bits
    issue_valid_i = 1'b1; issue_rd_addr_i = 5'd4;
    step();
    issue_rd_addr_i = 5'd8;
    step();
    idle_inputs();
    check("t6_busy", busy_o, 32'h110);
    int_valid_i = 1'b1; int_rd_addr_i = 5'd1; int_rd_data_i = 32'd1;
    fpu_valid_i = 1'b1; fpu_rd_addr_i = 5'd4; fpu_rd_data_i = 32'h44;
    step();
    int_rd_addr_i = 5'd2; int_rd_data_i = 32'd2;
    fpu_rd_addr_i = 5'd8; fpu_rd_data_i = 32'h88;
    check("t6_rdy_one", fpu_ready_o, 1);
    step();
    idle_inputs();
    check("t6_full", fpu_ready_o, 0);
    check("t6_wren_pre", rd_wren_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_rst_wren", rd_wren_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_rdy", fpu_ready_o, 1);
    step();
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t6_no_stale_%0d", k), rd_wren_o, 0);
    end
    check("t6_rdy_end", fpu_ready_o, 1);
    check("t6_busy_end", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
